log_scheduler: RTL and testbench

Shares one fixed-latency CORDIC log pipeline among NREQ requesters. Arbitrates round-robin, issuing at most one operand per cycle. Tracks in-flight operations with a valid/tag shift register matched to the pipeline depth, because the datapath carries no valid. Steers each result into a per-requester response FIFO, with credit-based flow control so that no result is ever dropped. Sits between the front-end normalisation units and the log pipeline; the parent instantiates both blocks.

---
 rtl/log_pkg.sv | 16 +
 rtl/log_rsp_fifo.sv | 51 +++++
 rtl/log_scheduler.sv | 132 +++++++++++++
 tb/tb_log_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared widths, default pipeline latency and the in-flight tracker entry
// for the log pipeline scheduler.
package log_pkg;

    localparam int MAN_W     = 24;
    localparam int EXP_W     = 38;
    localparam int LOG_W     = 25;
    localparam int LOG_LAT   = 25;
    localparam int TAG_MAX_W = 3;   // wide enough for up to 8 requesters

    typedef struct packed {
        logic                 vld;
        logic [TAG_MAX_W-1:0] tag;
    } trk_entry_t;

endpackage

// File: rtl/log_rsp_fifo.sv
// Per-requester response FIFO: registered output (no fall-through),
// simultaneous push/pop, occupancy count.
module log_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 63
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // what is valid, and an unreset array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/log_scheduler.sv
// Round-robin, credit-flow-controlled sharing of one fixed-latency log
// pipeline; a valid/tag shift register steers results into per-requester FIFOs.
module log_scheduler
    import log_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int LAT       = LOG_LAT,
    parameter int RES_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*MAN_W-1:0] req_man,
    input  logic [NREQ*EXP_W-1:0] req_exp,
    output logic [MAN_W-1:0]      pl_man,
    output logic [EXP_W-1:0]      pl_exp,
    input  logic [LOG_W-1:0]      pl_log,
    input  logic [EXP_W-1:0]      pl_exp_o,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*LOG_W-1:0] rsp_log,
    output logic [NREQ*EXP_W-1:0] rsp_exp,
    output logic                  busy
);

    localparam int TAG_W  = $clog2(NREQ);
    localparam int CRED_W = $clog2(RES_DEPTH + 1);
    localparam int CNT_W  = $clog2(RES_DEPTH) + 1;
    localparam int FW     = LOG_W + EXP_W;

    logic [CRED_W-1:0] credit_q [NREQ];
    logic [CRED_W-1:0] credit_d [NREQ];
    logic [TAG_W-1:0]  ptr_q, ptr_d;
    logic [TAG_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [NREQ-1:0]   rsp_push;
    logic [NREQ-1:0]   rsp_pop;
    trk_entry_t        trk_q [LAT];
    trk_entry_t        trk_in;
    logic              trk_any;
    logic              busy_q, busy_d;

    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier results; every output gets a default first so no latch appears.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx] && (credit_q[idx] != '0)) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        pl_man    = '0;
        pl_exp    = '0;
        ptr_d     = ptr_q;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            pl_man = req_man[gnt_idx*MAN_W +: MAN_W];
            pl_exp = req_exp[gnt_idx*EXP_W +: EXP_W];
            ptr_d  = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    assign rsp_pop = rsp_valid & rsp_ready;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            credit_d[i] = credit_q[i] - CRED_W'(req_ready[i]) + CRED_W'(rsp_pop[i]);
        end
    end

    // The pipeline carries no valid, so the tracker alone decides what is a result.
    always_comb begin
        trk_in  = '{vld: gnt_any, tag: TAG_MAX_W'(gnt_idx)};
        trk_any = 1'b0;
        for (int k = 0; k < LAT; k++) trk_any = trk_any | trk_q[k].vld;
        for (int i = 0; i < NREQ; i++) begin
            rsp_push[i] = trk_q[LAT-1].vld && (trk_q[LAT-1].tag == TAG_MAX_W'(i));
        end
        busy_d = gnt_any || trk_any || (|rsp_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < NREQ; i++) credit_q[i] <= CRED_W'(RES_DEPTH);
            for (int k = 0; k < LAT; k++)  trk_q[k] <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            for (int i = 0; i < NREQ; i++) credit_q[i] <= credit_d[i];
            trk_q[0] <= trk_in;
            for (int k = 1; k < LAT; k++)  trk_q[k] <= trk_q[k-1];
        end
    end

    assign busy = busy_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        logic [FW-1:0]    dout;
        logic [CNT_W-1:0] cnt;

        log_rsp_fifo #(
            .DEPTH (RES_DEPTH),
            .WIDTH (FW)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (rsp_push[i]),
            .data_i  ({pl_log, pl_exp_o}),
            .pop_i   (rsp_pop[i]),
            .data_o  (dout),
            .count_o (cnt)
        );

        assign rsp_valid[i]               = (cnt != '0);
        assign rsp_log[i*LOG_W +: LOG_W]  = dout[FW-1:EXP_W];
        assign rsp_exp[i*EXP_W +: EXP_W]  = dout[EXP_W-1:0];
    end

endmodule

// File: tb/tb_log_scheduler.sv
// Bench for log_scheduler: delay-line pipeline model, per-requester
// outstanding-result queues as reference, directed and random phases.
module tb_log_scheduler;
    import log_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 25;
    localparam int RD   = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*MAN_W-1:0] req_man;
    logic [NREQ*EXP_W-1:0] req_exp;
    logic [MAN_W-1:0]      pl_man;
    logic [EXP_W-1:0]      pl_exp;
    logic [LOG_W-1:0]      pl_log;
    logic [EXP_W-1:0]      pl_exp_o;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [NREQ*LOG_W-1:0] rsp_log;
    logic [NREQ*EXP_W-1:0] rsp_exp;
    logic                  busy;

    always #5 clk = ~clk;

    log_scheduler #(.NREQ(NREQ), .LAT(LAT), .RES_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_man(req_man), .req_exp(req_exp),
        .pl_man(pl_man), .pl_exp(pl_exp),
        .pl_log(pl_log), .pl_exp_o(pl_exp_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_log(rsp_log), .rsp_exp(rsp_exp),
        .busy(busy)
    );

    // Pipeline model: plain LAT-deep delay line, log = {0, man}, no reset.
    logic [MAN_W+EXP_W-1:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= {pl_man, pl_exp};
        for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
    end
    assign pl_log   = {1'b0, dl[LAT-1][MAN_W+EXP_W-1:EXP_W]};
    assign pl_exp_o = dl[LAT-1][EXP_W-1:0];

    // Reference: each requester's outstanding results (in flight or stored),
    // with the cycle from which each becomes visible.
    typedef struct {
        logic [LOG_W-1:0] log;
        logic [EXP_W-1:0] exp;
        int               ready_at;
    } rsp_t;

    rsp_t             mq [NREQ][$];
    int               ptr, now;
    bit               busy_exp;
    int               n_pass, n_fail, n_total;
    int               dut_gnt;
    bit               dut_pop [NREQ];
    logic [LOG_W-1:0] dut_pop_log [NREQ];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs set; checks this cycle, advances one clock.
    task automatic cycle();
        int g, idx, outstanding, nhot;
        logic [NREQ-1:0] exp_rdy, exp_v;
        #1;
        dut_gnt = -1;
        nhot = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin dut_gnt = i; nhot++; end
        if (nhot > 1) dut_gnt = -2;

        g = -1;
        for (int off = 0; off < NREQ; off++) begin
            idx = (ptr + off) % NREQ;
            if (g < 0 && req_valid[idx] && mq[idx].size() < RD) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("pl_man", pl_man, (g >= 0) ? req_man[g*MAN_W +: MAN_W] : '0);
        check("pl_exp", pl_exp, (g >= 0) ? req_exp[g*EXP_W +: EXP_W] : '0);
        check("busy", busy, busy_exp);

        outstanding = 0;
        for (int i = 0; i < NREQ; i++) begin
            outstanding += mq[i].size();
            exp_v[i] = (mq[i].size() > 0) && (mq[i][0].ready_at <= now);
        end
        check("rsp_valid", rsp_valid, exp_v);

        for (int i = 0; i < NREQ; i++) begin
            dut_pop[i] = rsp_valid[i] && rsp_ready[i];
            dut_pop_log[i] = rsp_log[i*LOG_W +: LOG_W];
            if (exp_v[i]) begin
                check($sformatf("rsp_log[%0d]", i), rsp_log[i*LOG_W +: LOG_W], mq[i][0].log);
                check($sformatf("rsp_exp[%0d]", i), rsp_exp[i*EXP_W +: EXP_W], mq[i][0].exp);
                if (rsp_ready[i]) void'(mq[i].pop_front());
            end
        end

        if (g >= 0) begin
            mq[g].push_back('{log: {1'b0, req_man[g*MAN_W +: MAN_W]},
                              exp: req_exp[g*EXP_W +: EXP_W],
                              ready_at: now + LAT + 1});
            ptr = (g + 1) % NREQ;
        end
        busy_exp = (outstanding > 0) || (g >= 0);
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) begin
            req_man[i*MAN_W +: MAN_W] = MAN_W'($urandom());
            req_exp[i*EXP_W +: EXP_W] = EXP_W'({$urandom(), $urandom()});
        end
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        rsp_ready = '1;
        repeat (n) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_pl_man"},    pl_man,    '0);
        check({tag, "_pl_exp"},    pl_exp,    '0);
        check({tag, "_rsp_valid"}, rsp_valid, '0);
        check({tag, "_rsp_log"},   rsp_log,   '0);
        check({tag, "_rsp_exp"},   rsp_exp[63:0], '0);
        check({tag, "_busy"},      busy,      '0);
    endtask

    initial begin
        int lat, cnt1, others, got, seq, nvalid;
        int gcount [NREQ];
        logic [LOG_W-1:0] got_v [8];

        n_pass = 0; n_fail = 0; n_total = 0;
        ptr = 0; now = 0; busy_exp = 1'b0;
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0; req_man = '0; req_exp = '0;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request and its latency
        req_valid = 4'b0001;
        req_man[0 +: MAN_W] = 24'h400000;
        req_exp[0 +: EXP_W] = 38'h5;
        cycle();
        check("single_gnt", dut_gnt, 0);
        req_valid = '0;
        lat = 1;
        while (!rsp_valid[0] && lat < 40) begin
            cycle();
            lat++;
        end
        check("single_latency", lat, LAT + 1);
        check("single_log", rsp_log[0 +: LOG_W], 25'h0400000);
        check("single_exp", rsp_exp[0 +: EXP_W], 38'h5);
        rsp_ready = 4'b0001;
        cycle();
        drain(5);

        // All requesters valid: strict rotation while credits last
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < 16; k++) begin
            randomize_data();
            cycle();
            check("rr_order", dut_gnt, (1 + k) % NREQ);
        end
        for (int k = 0; k < 60; k++) begin
            randomize_data();
            cycle();
        end
        drain(40);

        // Back-pressure on requester 1
        req_valid = '1;
        rsp_ready = 4'b1101;
        cnt1 = 0; others = 0;
        for (int k = 0; k < 60; k++) begin
            randomize_data();
            cycle();
            if (dut_gnt == 1) cnt1++;
            else if (dut_gnt >= 0) others++;
        end
        check("bp_grants_req1", cnt1, RD);
        check("bp_others_served", others >= 20, 1);
        check("bp_rsp_held", rsp_valid[1], 1'b1);
        rsp_ready = 4'b1111;
        cycle();
        rsp_ready = 4'b1101;
        cnt1 = 0;
        for (int k = 0; k < 30; k++) begin
            randomize_data();
            cycle();
            if (dut_gnt == 1) cnt1++;
        end
        check("bp_one_more", cnt1, 1);
        drain(40);

        // Credit boundary: pop and request in the same cycle at zero credit
        req_valid = 4'b0100;
        rsp_ready = '0;
        for (int k = 0; k < 35; k++) begin
            randomize_data();
            cycle();
        end
        check("cb_stored", rsp_valid[2], 1'b1);
        rsp_ready = 4'b0100;
        cycle();
        check("cb_no_grant_on_pop", dut_gnt, -1);
        rsp_ready = '0;
        cycle();
        check("cb_grant_next", dut_gnt, 2);
        drain(40);

        // Ordering on requester 3
        req_valid = 4'b1000;
        rsp_ready = '1;
        seq = 1; got = 0;
        for (int t = 0; t < 150 && got < 8; t++) begin
            req_man[3*MAN_W +: MAN_W] = MAN_W'(seq);
            req_exp[3*EXP_W +: EXP_W] = EXP_W'(seq);
            cycle();
            if (dut_gnt == 3) begin
                seq++;
                if (seq > 8) req_valid = '0;
            end
            if (dut_pop[3]) begin
                if (got < 8) got_v[got] = dut_pop_log[3];
                got++;
            end
        end
        check("order_count", got, 8);
        for (int k = 0; k < 8; k++) check($sformatf("order_%0d", k), got_v[k], LOG_W'(k + 1));
        drain(10);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            req_valid = NREQ'($urandom());
            rsp_ready = NREQ'($urandom());
            randomize_data();
            cycle();
        end
        drain(40);

        // Reset with operations in flight
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < 10; k++) begin
            randomize_data();
            cycle();
        end
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        ptr = 0;
        busy_exp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        now++;
        nvalid = 0;
        rsp_ready = '1;
        for (int k = 0; k < 2 * LAT; k++) begin
            cycle();
            if (rsp_valid != '0) nvalid++;
        end
        check("midrst_no_rsp", nvalid, 0);
        req_valid = '1;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) gcount[i] = 0;
        for (int k = 0; k < 40; k++) begin
            randomize_data();
            cycle();
            if (dut_gnt >= 0) gcount[dut_gnt]++;
        end
        for (int i = 0; i < NREQ; i++) check($sformatf("midrst_credit_%0d", i), gcount[i], RD);
        check("busy_active", busy, 1'b1);
        drain(40);
        check("busy_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
